// File: rtl/aes_decipher_iter.sv
// Iterative AES inverse cipher (FIPS-197 InvCipher), one round per clock.
// The first AddRoundKey with rk[Nr] is applied when the block is captured.
// After that come Nr-1 middle rounds, then a final round without InvMixColumns.
// Key_Expansion, the round-key schedule builder, is in this file too.

module Key_Expansion #(
    parameter int Nk = 4
) (
    input  logic [Nk*32-1:0]              key,
    output logic [(4*(Nk+6)+4)*32-1:0]    sch
);
    localparam int NR = Nk + 6;
    localparam int NW = 4 * NR + 4;

    // Multiply by x in GF(2^8) modulo 0x11B
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = p ^ (aa & {8{b[i]}});
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (exponent chain 1,3,7,...,127 then square); 0 maps to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 6; i++) begin
            r = gf_mul(gf_mul(r, r), x);
        end
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    // Forward S-box: field inverse followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t, r1, r2, r3, r4;
        t  = gf_inv(x);
        r1 = rotl1(t);
        r2 = rotl1(r1);
        r3 = rotl1(r2);
        r4 = rotl1(r3);
        return t ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Round constant byte for schedule step j (j >= 1)
    function automatic logic [7:0] rcon(input int j);
        logic [7:0] rc;
        rc = 8'h01;
        for (int k = 2; k <= j; k++) begin
            rc = xtime(rc);
        end
        return rc;
    endfunction

    // Schedule words, word 0 placed at the MSBs of sch
    for (genvar i = 0; i < NW; i++) begin : g_w
        logic [31:0] w_s;
        if (i < Nk) begin : g_key
            assign w_s = key[Nk*32-1-32*i -: 32];
        end else if ((i % Nk) == 0) begin : g_rot
            assign w_s = g_w[i-Nk].w_s
                       ^ sub_word({g_w[i-1].w_s[23:0], g_w[i-1].w_s[31:24]})
                       ^ {rcon(i / Nk), 24'h000000};
        end else if ((Nk > 6) && ((i % Nk) == 4)) begin : g_sub
            assign w_s = g_w[i-Nk].w_s ^ sub_word(g_w[i-1].w_s);
        end else begin : g_xor
            assign w_s = g_w[i-Nk].w_s ^ g_w[i-1].w_s;
        end
        assign sch[(NW-i)*32-1 -: 32] = w_s;
    end
endmodule

module aes_decipher_iter #(
    parameter int Nk = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [127:0]       cipher_in,
    input  logic [Nk*32-1:0]   key,
    output logic               ready,
    output logic               done,
    output logic [127:0]       plain_out
);
    localparam int NR    = Nk + 6;
    localparam int SCH_W = (4 * NR + 4) * 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_t;

    fsm_t               fsm_r, fsm_nxt_s;
    logic [3:0]         rnd_r, rnd_nxt_s;
    logic [127:0]       state_r, state_nxt_s;
    logic [Nk*32-1:0]   key_r, key_nxt_s;
    logic [127:0]       plain_out_r, plain_nxt_s;
    logic               done_r, done_nxt_s;

    logic [Nk*32-1:0]   ke_key_s;
    logic [SCH_W-1:0]   sch_s;
    logic [3:0]         rk_idx_s;
    logic [127:0]       rk_s;
    logic [127:0]       inv_sr_sb_s;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = p ^ (aa & {8{b[i]}});
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 6; i++) begin
            r = gf_mul(gf_mul(r, r), x);
        end
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    // Inverse S-box: inverse affine transform, then field inverse
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] r1, r3, r6;
        r1 = rotl1(x);
        r3 = rotl1(rotl1(r1));
        r6 = rotl1(rotl1(rotl1(r3)));
        return gf_inv(r1 ^ r3 ^ r6 ^ 8'h05);
    endfunction

    // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4]
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int k = 0; k < 16; k++) begin
            o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Schedule source: the live key while idle, so the capture-cycle AddRoundKey
    // sees rk[Nr] of the key being captured; the held key while running
    always_comb begin
        if (fsm_r == ST_IDLE) begin
            ke_key_s = key;
        end else begin
            ke_key_s = key_r;
        end
    end

    Key_Expansion #(.Nk(Nk)) u_key_expansion (
        .key (ke_key_s),
        .sch (sch_s)
    );

    // Round-key select: rk[Nr] on capture, rk[rnd] while running
    always_comb begin
        if (fsm_r == ST_IDLE) begin
            rk_idx_s = 4'(NR);
        end else begin
            rk_idx_s = rnd_r;
        end
        rk_s = sch_s[SCH_W - 1 - 128 * int'(rk_idx_s) -: 128];
    end

    // Shared front half of every round
    always_comb begin
        inv_sr_sb_s = inv_sub_bytes(inv_shift_rows(state_r));
    end

    // Next-state and datapath update
    always_comb begin
        fsm_nxt_s   = fsm_r;
        rnd_nxt_s   = rnd_r;
        state_nxt_s = state_r;
        key_nxt_s   = key_r;
        plain_nxt_s = plain_out_r;
        done_nxt_s  = 1'b0;
        case (fsm_r)
            ST_IDLE: begin
                if (start) begin
                    key_nxt_s   = key;
                    state_nxt_s = cipher_in ^ rk_s;
                    rnd_nxt_s   = 4'(NR - 1);
                    fsm_nxt_s   = ST_RUN;
                end else begin
                    fsm_nxt_s   = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rnd_r != 4'd0) begin
                    state_nxt_s = inv_mix_columns(inv_sr_sb_s ^ rk_s);
                    rnd_nxt_s   = rnd_r - 4'd1;
                end else begin
                    plain_nxt_s = inv_sr_sb_s ^ rk_s;
                    done_nxt_s  = 1'b1;
                    fsm_nxt_s   = ST_IDLE;
                end
            end
            default: begin
                fsm_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_r       <= ST_IDLE;
            rnd_r       <= 4'd0;
            state_r     <= 128'h0;
            key_r       <= '0;
            plain_out_r <= 128'h0;
            done_r      <= 1'b0;
        end else begin
            fsm_r       <= fsm_nxt_s;
            rnd_r       <= rnd_nxt_s;
            state_r     <= state_nxt_s;
            key_r       <= key_nxt_s;
            plain_out_r <= plain_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    assign ready     = (fsm_r == ST_IDLE);
    assign done      = done_r;
    assign plain_out = plain_out_r;
endmodule

// File: tb/tb_aes_decipher_iter.sv
// Directed bench for aes_decipher_iter: FIPS-197 vectors for all three key sizes,
// busy/input-change, back-to-back and mid-run reset sequences.

module tb_aes_decipher_iter;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start4 = 1'b0, start6 = 1'b0, start8 = 1'b0;
    logic [127:0] key4 = '0;
    logic [191:0] key6 = '0;
    logic [255:0] key8 = '0;
    logic [127:0] ct4 = '0, ct6 = '0, ct8 = '0;
    logic         ready4, ready6, ready8;
    logic         done4, done6, done8;
    logic [127:0] pt4, pt6, pt8;

    int n_checks = 0;
    int n_pass   = 0;
    int dcnt4 = 0, dcnt6 = 0, dcnt8 = 0;

    typedef struct {
        int           nk;
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;
    vec_t vecs [4];

    aes_decipher_iter #(.Nk(4)) u_dut4 (.clk(clk), .reset(reset), .start(start4), .cipher_in(ct4),
        .key(key4), .ready(ready4), .done(done4), .plain_out(pt4));
    aes_decipher_iter #(.Nk(6)) u_dut6 (.clk(clk), .reset(reset), .start(start6), .cipher_in(ct6),
        .key(key6), .ready(ready6), .done(done6), .plain_out(pt6));
    aes_decipher_iter #(.Nk(8)) u_dut8 (.clk(clk), .reset(reset), .start(start8), .cipher_in(ct8),
        .key(key8), .ready(ready8), .done(done8), .plain_out(pt8));

    always #5 clk = ~clk;

    // Count done pulses per instance
    always @(negedge clk) begin
        if (done4 === 1'b1) dcnt4 <= dcnt4 + 1;
        if (done6 === 1'b1) dcnt6 <= dcnt6 + 1;
        if (done8 === 1'b1) dcnt8 <= dcnt8 + 1;
    end

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic sel_done(input int nk);
        case (nk)
            4:       return done4;
            6:       return done6;
            default: return done8;
        endcase
    endfunction

    function automatic logic sel_ready(input int nk);
        case (nk)
            4:       return ready4;
            6:       return ready6;
            default: return ready8;
        endcase
    endfunction

    function automatic logic [127:0] sel_pt(input int nk);
        case (nk)
            4:       return pt4;
            6:       return pt6;
            default: return pt8;
        endcase
    endfunction

    // Drive start for one cycle (the current cycle is cycle 0), return in cycle 1
    task automatic pulse_start(input int nk, input logic [255:0] k, input logic [127:0] c);
        case (nk)
            4:       begin key4 = k[255:128]; ct4 = c; start4 = 1'b1; end
            6:       begin key6 = k[255:64];  ct6 = c; start6 = 1'b1; end
            default: begin key8 = k;          ct8 = c; start8 = 1'b1; end
        endcase
        @(posedge clk); #1;
        start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    endtask

    // Called in cycle 1; returns in the done cycle (or after budget with cyc=-1)
    task automatic wait_done(input int nk, input int budget, output int cyc,
                             output logic [127:0] pt, output logic rdy);
        cyc = -1; pt = '0; rdy = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            if (sel_done(nk) === 1'b1) begin
                cyc = c; pt = sel_pt(nk); rdy = sel_ready(nk);
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int           cyc, d0, d1, d2;
        logic [127:0] ptv;
        logic         rdy, hold_ok;

        vecs[0] = '{4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
        vecs[1] = '{4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
        vecs[2] = '{6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                    128'hdda97ca4864cdfe06eaf70a0ec0d7191, 128'h00112233445566778899aabbccddeeff};
        vecs[3] = '{8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff};

        // Reset held two cycles with start asserted on every instance
        key4 = vecs[0].key[255:128]; ct4 = vecs[0].ct;
        key6 = vecs[2].key[255:64];  ct6 = vecs[2].ct;
        key8 = vecs[3].key;          ct8 = vecs[3].ct;
        start4 = 1'b1; start6 = 1'b1; start8 = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready4", 256'(ready4), 256'(1)); check("rst_done4", 256'(done4), 256'(0)); check("rst_pt4", 256'(pt4), 256'(0));
        check("rst_ready6", 256'(ready6), 256'(1)); check("rst_done6", 256'(done6), 256'(0)); check("rst_pt6", 256'(pt6), 256'(0));
        check("rst_ready8", 256'(ready8), 256'(1)); check("rst_done8", 256'(done8), 256'(0)); check("rst_pt8", 256'(pt8), 256'(0));
        reset = 1'b0; start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
        d0 = dcnt4; d1 = dcnt6; d2 = dcnt8;
        repeat (20) @(posedge clk);
        #1;
        check("rst_nodone4", 256'(dcnt4 - d0), 256'(0));
        check("rst_nodone6", 256'(dcnt6 - d1), 256'(0));
        check("rst_nodone8", 256'(dcnt8 - d2), 256'(0));

        // Known-answer vectors: latency Nr+1, ready in done cycle, one-cycle pulse
        for (int i = 0; i < 4; i++) begin
            pulse_start(vecs[i].nk, vecs[i].key, vecs[i].ct);
            wait_done(vecs[i].nk, 40, cyc, ptv, rdy);
            check($sformatf("kat%0d_cycle", i), 256'(cyc), 256'(vecs[i].nk + 7));
            check($sformatf("kat%0d_plain", i), 256'(ptv), 256'(vecs[i].pt));
            check($sformatf("kat%0d_ready", i), 256'(rdy), 256'(1));
            @(posedge clk); #1;
            check($sformatf("kat%0d_done_low", i), 256'(sel_done(vecs[i].nk)), 256'(0));
        end

        // Busy: inputs change at cycle 3, extra start at cycle 5
        d0 = dcnt4;
        pulse_start(4, vecs[0].key, vecs[0].ct);
        cyc = -1; ptv = '0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 1)  check("busy_ready_c1", 256'(ready4), 256'(0));
            if (c == 10) check("busy_ready_c10", 256'(ready4), 256'(0));
            if (c == 3) begin key4 = vecs[1].key[255:128]; ct4 = vecs[1].ct; end
            if (c == 5) start4 = 1'b1;
            if (c == 6) start4 = 1'b0;
            if (done4 === 1'b1 && cyc < 0) begin cyc = c; ptv = pt4; end
            @(posedge clk); #1;
        end
        check("busy_cycle", 256'(cyc), 256'(11));
        check("busy_plain", 256'(ptv), 256'(vecs[0].pt));
        check("busy_one_done", 256'(dcnt4 - d0), 256'(1));

        // Back-to-back: second start in the done cycle of the first
        pulse_start(4, vecs[0].key, vecs[0].ct);
        wait_done(4, 40, cyc, ptv, rdy);
        check("b2b_first_cycle", 256'(cyc), 256'(11));
        check("b2b_first_plain", 256'(ptv), 256'(vecs[0].pt));
        pulse_start(4, vecs[1].key, vecs[1].ct);
        hold_ok = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            if (pt4 !== vecs[0].pt || done4 !== 1'b0) hold_ok = 1'b0;
            @(posedge clk); #1;
        end
        check("b2b_hold", 256'(hold_ok), 256'(1));
        check("b2b_second_done", 256'(done4), 256'(1));
        check("b2b_second_plain", 256'(pt4), 256'(vecs[1].pt));

        // Mid-run reset at cycle 6, then a fresh operation
        @(posedge clk); #1;
        pulse_start(4, vecs[1].key, vecs[1].ct);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mrst_plain", 256'(pt4), 256'(0));
        check("mrst_ready", 256'(ready4), 256'(1));
        check("mrst_done", 256'(done4), 256'(0));
        d0 = dcnt4;
        repeat (20) @(posedge clk);
        #1;
        check("mrst_nodone", 256'(dcnt4 - d0), 256'(0));
        check("mrst_plain_held", 256'(pt4), 256'(0));
        pulse_start(4, vecs[0].key, vecs[0].ct);
        wait_done(4, 40, cyc, ptv, rdy);
        check("mrst_after_cycle", 256'(cyc), 256'(11));
        check("mrst_after_plain", 256'(ptv), 256'(vecs[0].pt));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
